// File: rtl/ppu_pipeline_control.sv
// PPU pipeline control: decodes the ID instruction into a 17-bit control word
// and carries it with its destination register through EX, MEM and WB.
module ppu_pipeline_control #(
  parameter int INSTR_W   = 32,
  parameter int REG_AW    = 5,
  parameter int CTRL_W    = 17,
  parameter int HAZARD_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               id_valid,
  input  logic               hold,
  input  logic               flush,
  output logic [CTRL_W-1:0]  ex_ctrl,
  output logic [CTRL_W-1:0]  mem_ctrl,
  output logic [CTRL_W-1:0]  wb_ctrl,
  output logic [REG_AW-1:0]  ex_dest,
  output logic [REG_AW-1:0]  mem_dest,
  output logic [REG_AW-1:0]  wb_dest,
  output logic               stall_out,
  output logic               illegal
);

  localparam int CW = 17;

  localparam logic [CW-1:0] SO_SIMM = 17'h04000;
  localparam logic [CW-1:0] SO_LUI  = 17'h0C000;
  localparam logic [CW-1:0] A_SUB   = 17'h00800;
  localparam logic [CW-1:0] A_AND   = 17'h01000;
  localparam logic [CW-1:0] A_OR    = 17'h01800;
  localparam logic [CW-1:0] A_PASSB = 17'h02000;
  localparam logic [CW-1:0] A_SLT   = 17'h02800;
  localparam logic [CW-1:0] LOAD    = 17'h00400;
  localparam logic [CW-1:0] RF      = 17'h00200;
  localparam logic [CW-1:0] BR      = 17'h00100;
  localparam logic [CW-1:0] TA      = 17'h00080;
  localparam logic [CW-1:0] SZ_W    = 17'h00040;
  localparam logic [CW-1:0] WR      = 17'h00010;
  localparam logic [CW-1:0] SE      = 17'h00008;
  localparam logic [CW-1:0] HI      = 17'h00004;
  localparam logic [CW-1:0] LO      = 17'h00002;
  localparam logic [CW-1:0] MEN     = 17'h00001;

  typedef struct packed {
    logic [CW-1:0]     ctrl;
    logic [REG_AW-1:0] dest;
  } stage_t;

  stage_t ex_q, mem_q, wb_q, id_dc;
  logic   ill_q, ill_dc, reads_rt, hazard;

  logic [5:0]        op, fn;
  logic [REG_AW-1:0] rs, rt, rd;

  assign op = id_instr[INSTR_W-1 -: 6];
  assign fn = id_instr[5:0];
  assign rs = REG_AW'(id_instr[25:21]);
  assign rt = REG_AW'(id_instr[20:16]);
  assign rd = REG_AW'(id_instr[15:11]);

  always_comb begin
    id_dc.ctrl = '0;
    ill_dc     = 1'b0;
    reads_rt   = 1'b0;
    if (id_valid && id_instr != '0) begin
      case (op)
        6'b000000: begin
          reads_rt = 1'b1;
          case (fn)
            6'b100001: id_dc.ctrl = RF;
            6'b100011: id_dc.ctrl = A_SUB | RF;
            6'b100100: id_dc.ctrl = A_AND | RF;
            6'b100101: id_dc.ctrl = A_OR | RF;
            6'b101010: id_dc.ctrl = A_SLT | RF;
            6'b001000: id_dc.ctrl = TA;
            6'b011000: id_dc.ctrl = HI | LO;
            default:   ill_dc = 1'b1;
          endcase
        end
        6'b001001: id_dc.ctrl = SO_SIMM | RF;
        6'b001111: id_dc.ctrl = SO_LUI | A_PASSB | RF;
        6'b100000: id_dc.ctrl = SO_SIMM | LOAD | RF | MEN | SE;
        6'b100100: id_dc.ctrl = SO_SIMM | LOAD | RF | MEN;
        6'b100011: id_dc.ctrl = SO_SIMM | LOAD | RF | MEN | SZ_W;
        6'b101000: begin id_dc.ctrl = SO_SIMM | MEN | WR;        reads_rt = 1'b1; end
        6'b101011: begin id_dc.ctrl = SO_SIMM | MEN | WR | SZ_W; reads_rt = 1'b1; end
        6'b000100: begin id_dc.ctrl = BR;                        reads_rt = 1'b1; end
        6'b000111: id_dc.ctrl = BR;
        6'b000010: id_dc.ctrl = TA;
        6'b000011: id_dc.ctrl = TA | RF;
        default:   ill_dc = 1'b1;
      endcase
    end
  end

  always_comb begin
    id_dc.dest = '0;
    if (id_dc.ctrl[9]) begin
      if (op == 6'b000000)      id_dc.dest = rd;
      else if (op == 6'b000011) id_dc.dest = REG_AW'(31);
      else                      id_dc.dest = rt;
    end
  end

  // Only instructions that actually read rt compare against it.
  always_comb begin
    hazard = 1'b0;
    if (HAZARD_EN != 0)
      hazard = ex_q.ctrl[10] && ex_q.dest != '0 && id_valid &&
               (ex_q.dest == rs || (reads_rt && ex_q.dest == rt));
  end

  assign stall_out = hold | (hazard & ~flush);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      ill_q <= 1'b0;
    end else if (!hold) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (flush || hazard) begin
        ex_q  <= '0;
        ill_q <= 1'b0;
      end else begin
        ex_q  <= id_dc;
        ill_q <= ill_dc;
      end
    end
  end

  assign ex_ctrl  = CTRL_W'(ex_q.ctrl);
  assign mem_ctrl = CTRL_W'(mem_q.ctrl);
  assign wb_ctrl  = CTRL_W'(wb_q.ctrl);
  assign ex_dest  = ex_q.dest;
  assign mem_dest = mem_q.dest;
  assign wb_dest  = wb_q.dest;
  assign illegal  = ill_q;

endmodule
